// File: rtl/mips32_pkg.sv
// Shared constants and types for the MIPS32 boot loader.
// Stream: CNT_HI CNT_LO ADR_HI ADR_LO payload CHK, big-endian.
package mips32_pkg;

    localparam int ADDR_W    = 10;
    localparam int MEM_DEPTH = 1024;

    typedef enum logic [2:0] {
        IDLE,
        HDR_CNT,
        HDR_ADDR,
        DATA,
        CHK,
        DONE,
        ERR
    } ld_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CNT  = 2'd1;
    localparam logic [1:0] ERR_ADDR = 2'd2;
    localparam logic [1:0] ERR_CHK  = 2'd3;

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream valid/ready link from the UART/JTAG bridge.
interface mips32_prog_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, in_data, input in_ready);
    modport slave  (input in_valid, in_data, output in_ready);

endinterface

// File: rtl/mips32_byte_assembler.sv
// Packs four bytes MSB-first into a word; o_word_ready marks
// the cycle the fourth byte is accepted.
module mips32_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_data};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_data};
    assign o_word_ready = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: byte stream -> unified memory write port,
// then releases the core with core_run after a good checksum.
module mips32_prog_loader #(
    parameter int ADDR_W    = mips32_pkg::ADDR_W,
    parameter int MEM_DEPTH = mips32_pkg::MEM_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    mips32_prog_loader_if.slave s_in,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                core_run,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    import mips32_pkg::*;

    ld_state_e         r_state;
    ld_state_e         w_nstate;
    logic              r_hb;
    logic [7:0]        r_hdr_hi;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_widx;
    logic [7:0]        r_chk;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [1:0]        r_err_code;

    logic              w_ready;
    logic              w_acc;
    logic              w_start;
    logic [15:0]       w_hdr_val;
    logic [16:0]       w_end;
    logic              w_cnt_bad;
    logic              w_addr_bad;
    logic              w_last_word;
    logic [31:0]       w_asm_word;
    logic              w_word;

    assign w_acc       = s_in.in_valid && w_ready;
    assign w_start     = start && (r_state == IDLE || r_state == DONE
                                   || r_state == ERR);
    assign w_hdr_val   = {r_hdr_hi, s_in.in_data};
    assign w_cnt_bad   = (w_hdr_val == 16'd0)
                         || (w_hdr_val > 16'(MEM_DEPTH));
    assign w_end       = {1'b0, w_hdr_val} + {1'b0, r_cnt};
    assign w_addr_bad  = w_end > 17'(MEM_DEPTH);
    assign w_last_word = (r_widx + 16'd1) == r_cnt;

    mips32_byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_start),
        .i_valid      (w_acc && r_state == DATA),
        .i_data       (s_in.in_data),
        .o_word       (w_asm_word),
        .o_word_ready (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            IDLE:     if (start) w_nstate = HDR_CNT;
            HDR_CNT:  if (w_acc && r_hb)
                          w_nstate = w_cnt_bad ? ERR : HDR_ADDR;
            HDR_ADDR: if (w_acc && r_hb)
                          w_nstate = w_addr_bad ? ERR : DATA;
            DATA:     if (w_word && w_last_word) w_nstate = CHK;
            CHK:      if (w_acc)
                          w_nstate = (s_in.in_data == r_chk) ? DONE : ERR;
            DONE:     if (start) w_nstate = HDR_CNT;
            ERR:      if (start) w_nstate = HDR_CNT;
            default:  w_nstate = IDLE;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        core_run = 1'b0;
        unique case (r_state)
            HDR_CNT, HDR_ADDR, DATA, CHK: begin
                w_ready = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                core_run = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    // Header bytes arrive in pairs; r_hb marks the low byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb        <= 1'b0;
            r_hdr_hi    <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_widx      <= '0;
            r_chk       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start) begin
                r_hb       <= 1'b0;
                r_hdr_hi   <= '0;
                r_cnt      <= '0;
                r_addr     <= '0;
                r_widx     <= '0;
                r_chk      <= '0;
                r_err_code <= ERR_NONE;
            end else begin
                unique case (r_state)
                    HDR_CNT: if (w_acc) begin
                        r_hb     <= ~r_hb;
                        r_hdr_hi <= s_in.in_data;
                        if (r_hb) begin
                            r_cnt <= w_hdr_val;
                            if (w_cnt_bad) r_err_code <= ERR_CNT;
                        end
                    end
                    HDR_ADDR: if (w_acc) begin
                        r_hb     <= ~r_hb;
                        r_hdr_hi <= s_in.in_data;
                        if (r_hb) begin
                            r_addr <= w_hdr_val[ADDR_W-1:0];
                            if (w_addr_bad) r_err_code <= ERR_ADDR;
                        end
                    end
                    DATA: if (w_acc) begin
                        r_chk <= r_chk ^ s_in.in_data;
                        if (w_word) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr + r_widx[ADDR_W-1:0];
                            r_mem_wdata <= w_asm_word;
                            r_widx      <= r_widx + 16'd1;
                        end
                    end
                    CHK: if (w_acc && s_in.in_data != r_chk)
                        r_err_code <= ERR_CHK;
                    default: ;
                endcase
            end
        end
    end

    assign s_in.in_ready = w_ready;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench for mips32_prog_loader: expected writes are
// queued as payload is driven and matched on each mem_we.
module tb_mips32_prog_loader;
    import mips32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_run, busy, done, err;
    logic [1:0]  err_code;

    mips32_prog_loader_if ifc ();

    mips32_prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_in      (ifc.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_run  (core_run),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] words [3] = '{32'h2800000A, 32'h28210014, 32'h0CE77800};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({ifc.in_ready, mem_we, core_run, busy, done, err,
                    err_code, mem_addr, mem_wdata});
    endfunction

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (sb.size() == 0) begin
                check("we_unexp", 64'(mem_we), 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.a));
                check("wr_data", 64'(mem_wdata), 64'(e.d));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int n;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
            check("rdy_gap", 64'(ifc.in_ready), 64'd1);
        end
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        n = 0;
        while (!ifc.in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) check("rdy_timeout", 64'(ifc.in_ready), 64'd1);
    endtask

    task automatic end_stream();
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] v);
        send_byte(v[15:8], 0);
        send_byte(v[7:0], 0);
    endtask

    task automatic send_load(input logic [15:0] addr, input logic [7:0] flip,
                             input int maxgap, input int nbytes);
        logic [7:0]  c;
        logic [7:0]  b;
        logic [31:0] w;
        int          k;
        c = 8'h00;
        k = 0;
        send_hdr(16'd3);
        send_hdr(addr);
        for (int i = 0; i < 3; i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                if (k < nbytes) begin
                    b = w[31-8*j -: 8];
                    c = c ^ b;
                    if (j == 3)
                        sb.push_back(wr_t'{a: addr[9:0] + 10'(i), d: w});
                    send_byte(b, maxgap);
                    k++;
                end
            end
        end
        if (nbytes >= 12) begin
            send_byte(c ^ flip, maxgap);
            end_stream();
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("end_timeout", 64'(done | err), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_outs", outs(), 64'd0);
        rst_n = 1'b1;

        pulse_start();
        check("busy_hdr", 64'(busy), 64'd1);
        send_load(16'h0000, 8'h00, 0, 12);
        wait_end();
        check("t1_done", 64'(done), 64'd1);
        check("t1_run", 64'(core_run), 64'd1);
        check("t1_code", 64'(err_code), 64'(ERR_NONE));
        check("t1_rdy", 64'(ifc.in_ready), 64'd0);
        check("t1_sb", 64'(sb.size()), 64'd0);

        pulse_start();
        check("t2_run_drop", 64'(core_run), 64'd0);
        check("t2_done_drop", 64'(done), 64'd0);
        send_load(16'h0000, 8'h00, 5, 12);
        wait_end();
        check("t2_done", 64'(done), 64'd1);
        check("t2_run", 64'(core_run), 64'd1);
        check("t2_sb", 64'(sb.size()), 64'd0);

        pulse_start();
        send_hdr(16'h0000);
        end_stream();
        wait_end();
        check("t3a_err", 64'(err), 64'd1);
        check("t3a_code", 64'(err_code), 64'(ERR_CNT));
        check("t3a_run", 64'(core_run), 64'd0);
        pulse_start();
        check("t3_clr", 64'({err, err_code}), 64'd0);
        send_hdr(16'h0401);
        end_stream();
        wait_end();
        check("t3b_code", 64'(err_code), 64'(ERR_CNT));
        check("t3b_run", 64'(core_run), 64'd0);

        pulse_start();
        send_hdr(16'h0004);
        send_hdr(16'h03FE);
        end_stream();
        wait_end();
        check("t4_err", 64'(err), 64'd1);
        check("t4_code", 64'(err_code), 64'(ERR_ADDR));
        pulse_start();
        send_load(16'h03FD, 8'h00, 0, 12);
        wait_end();
        check("t4_done", 64'(done), 64'd1);
        check("t4_code0", 64'(err_code), 64'(ERR_NONE));
        check("t4_sb", 64'(sb.size()), 64'd0);

        pulse_start();
        send_load(16'h0010, 8'h01, 0, 12);
        wait_end();
        check("t5_err", 64'(err), 64'd1);
        check("t5_code", 64'(err_code), 64'(ERR_CHK));
        check("t5_run", 64'(core_run), 64'd0);
        check("t5_sb", 64'(sb.size()), 64'd0);

        pulse_start();
        send_load(16'h0100, 8'h00, 0, 8);
        @(posedge clk);
        #1;
        check("t6_we_pre", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", outs(), 64'd0);
        sb.delete();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_load(16'h0020, 8'h00, 0, 12);
        wait_end();
        check("t6_done", 64'(done), 64'd1);
        check("t6_run", 64'(core_run), 64'd1);
        check("t6_sb", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
Upstream boot block for the two-phase MIPS32 pipeline core: accepts a byte stream (UART/JTAG bridge) over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes the words into the core's 1024x32 unified memory through a dedicated write port. Checks an XOR checksum, then releases the core from halt with a level `core_run`. The core's PC starts at word 0, so `core_run` is the only sequencing link between loader and pipeline.

Parameters:
ADDR_W, 10, memory word-address width
MEM_DEPTH, 1024, number of 32-bit memory words; upper bound for start_addr + word_count

Ports:
clk  in  1  single system clock; core's clk1/clk2 derive from it outside this block
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader accepts byte when in_valid && in_ready
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
core_run  out  1  level; high releases core (drives HALTED deassert)
busy  out  1  high in HDR_CNT/HDR_ADDR/DATA/CHK
done  out  1  level; load completed with good checksum
err  out  1  level; load aborted
err_code  out  2  0 none, 1 zero/oversize count, 2 address overflow, 3 checksum mismatch

Behaviour:
- Reset (async assert, sync deassert usage): state=IDLE. All outputs 0, including in_ready, mem_we, core_run, err_code. Internal count, address, byte index and checksum cleared. Reset mid-load abandons the load; partially written memory is not erased.
- Stream format, big-endian: CNT_HI, CNT_LO (word_count, 16 b); ADR_HI, ADR_LO (start_addr, 16 b); 4*word_count payload bytes; CHK byte. CHK is the XOR of payload bytes only.
- States:
  - IDLE: in_ready=0. start -> HDR_CNT.
  - HDR_CNT: in_ready=1. After 2 bytes, word_count is validated:
    - 0 or > MEM_DEPTH -> ERR, code 1.
    - otherwise -> HDR_ADDR.
  - HDR_ADDR: in_ready=1. After 2 bytes:
    - start_addr + word_count > MEM_DEPTH (17-bit compare) -> ERR, code 2.
    - otherwise -> DATA.
  - DATA: in_ready=1. Bytes are shifted into a 32-bit assembler, first byte to [31:24]. The accepting edge of the 4th byte registers mem_we=1, mem_addr=start_addr+word_index, mem_wdata=assembled word; mem_we drops the next cycle. Every payload byte is XORed into the running checksum. After the last word -> CHK.
  - CHK: in_ready=1. One byte:
    - equals the running checksum -> DONE.
    - else -> ERR, code 3.
  - DONE: done=1, core_run=1, in_ready=0. start -> core_run=0, done=0, clear internal state, go to HDR_CNT (reload).
  - ERR: err=1, core_run=0, in_ready=0. start -> clear err/err_code, go to HDR_CNT.
- Handshake: a byte is consumed only on in_valid&&in_ready. in_valid gaps of any length are allowed; state holds.
- start while busy is ignored. Simultaneous start and valid byte in IDLE: only start acts, because in_ready=0 in IDLE.
- Address wraps never occur by construction of the overflow check. mem_addr holds its last value when mem_we=0.
- Throughput: one byte per cycle sustained; write latency one cycle after the 4th byte.

Decomposition:
- Shared package mips32_pkg: ADDR_W/MEM_DEPTH constants, loader state enum (IDLE, HDR_CNT, HDR_ADDR, DATA, CHK, DONE, ERR), err_code constants.
- One natural sub-module: mips32_byte_assembler. It holds the 4-byte shift register, byte index and word-ready pulse, and is reusable for a future data-memory dump path.

Test Plan:
- Load 3 words at addr 0 (bytes 00 03 00 00, words 2800000A 28210014 0CE77800, matching CHK), no gaps -> mem_we pulses at addr 0,1,2 with those words; done=1, core_run=1, err_code=0.
- Same stream with random in_valid gaps of 0-5 cycles -> identical writes and done; in_ready stays 1 throughout the load.
- Count 0x0000, then count 0x0401 -> ERR, err_code=1, no mem_we, core_run=0.
- Count 4, addr 0x03FE -> ERR, err_code=2, no mem_we; following start plus a valid stream -> done=1.
- Good payload with CHK XOR 0x01 -> all words written, then ERR, err_code=3, core_run=0.
- rst_n low after 2 of 3 words written -> all outputs 0 immediately (async); start plus a new stream then loads normally.
